// File: rtl/ledseq_pkg.sv
// ledseq_pkg: shared mode encodings and the bit-reverse helper used by the
// LED sequencer and its PWM stage.
package ledseq_pkg;

  typedef enum logic [1:0] {
    LEDSEQ_BOUNCE = 2'd0,
    LEDSEQ_WRAPL  = 2'd1,
    LEDSEQ_WRAPR  = 2'd2,
    LEDSEQ_FILL   = 2'd3
  } ledseq_mode_e;

  localparam int LEDSEQ_REV_MAXW = 32;

  // Reverse the low 'width' bits of value; bits above width come back as zero.
  function automatic logic [LEDSEQ_REV_MAXW-1:0] ledseq_bitrev(
    input logic [LEDSEQ_REV_MAXW-1:0] value,
    input int                         width
  );
    logic [LEDSEQ_REV_MAXW-1:0] result;
    result = '0;
    for (int i = 0; i < LEDSEQ_REV_MAXW; i++) begin
      if (i < width) result[i] = value[width-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/ledseq_pwm.sv
// ledseq_pwm: free-running PWM counter compared (bit-reversed) against each
// LED's brightness level; produces registered LED outputs. Bit reversal
// spreads the on-time evenly over the PWM frame instead of one burst.
module ledseq_pwm
  import ledseq_pkg::*;
#(
  parameter int NLEDS = 8,
  parameter int NPWM  = 9
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NLEDS*NPWM-1:0]  i_levels,
  output logic [NLEDS-1:0]       o_led
);

  logic [NPWM-1:0]  pwm_cnt_reg;
  logic [NPWM-1:0]  cmp_val;
  logic [NLEDS-1:0] led_next;

  // Free-running PWM frame counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pwm_cnt_reg <= '0;
    else            pwm_cnt_reg <= pwm_cnt_reg + NPWM'(1);
  end

  assign cmp_val = NPWM'(ledseq_bitrev(LEDSEQ_REV_MAXW'(pwm_cnt_reg), NPWM));

  // Full-scale and zero levels are forced so full-scale is truly always on.
  generate
    for (genvar gi = 0; gi < NLEDS; gi++) begin : g_cmp
      logic [NPWM-1:0] level;
      assign level        = i_levels[gi*NPWM +: NPWM];
      assign led_next[gi] = (&level)        ? 1'b1 :
                            (level == '0)   ? 1'b0 :
                            (cmp_val < level);
    end
  endgenerate

  // Register the LED pins so they never glitch on comparator settling.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_led <= '0;
    else            o_led <= led_next;
  end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: moving "owner" light with PWM-faded tail for PMod LED boards.
// Modes: bounce, wrap-left, wrap-right, fill; run-time step period (0 = frozen).
// Build option LED_SEQUENCER_HALFDECAY_EN: tail halves each step instead of
// dropping to NTAIL and counting down linearly.
module led_sequencer
  import ledseq_pkg::*;
#(
  parameter int NLEDS   = 8,
  parameter int CTRBITS = 25,
  parameter int NPWM    = 9,
  parameter int NTAIL   = 4,
  parameter int PW      = $clog2(NLEDS)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic [1:0]         i_mode,
  input  logic [CTRBITS-1:0] i_period,
  output logic [NLEDS-1:0]   o_led,
  output logic               o_step,
  output logic [PW-1:0]      o_pos
);

  logic [CTRBITS-1:0]    ctr_reg, ctr_next;
  logic                  step_tick;
  logic [NLEDS-1:0]      owner_reg, owner_next;
  logic                  dir_up_reg, dir_up_next;
  logic                  owner_onehot;
  logic [NLEDS*NPWM-1:0] levels_flat;
  ledseq_mode_e          mode;

  assign mode = ledseq_mode_e'(i_mode);

  // Step timer: terminal count (or a count stranded above a shrunk period) steps.
  always_comb begin
    ctr_next  = '0;
    step_tick = 1'b0;
    if (i_enable && (i_period != '0)) begin
      if (ctr_reg >= i_period - CTRBITS'(1)) step_tick = 1'b1;
      else                                   ctr_next  = ctr_reg + CTRBITS'(1);
    end
  end

  // Step counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) ctr_reg <= '0;
    else            ctr_reg <= ctr_next;
  end

  // Gate with reset so no step pulse is visible while held in reset.
  assign o_step = step_tick & i_reset_n;

  assign owner_onehot = (owner_reg != '0) &&
                        ((owner_reg & (owner_reg - NLEDS'(1))) == '0);

  // Owner/direction next state; a lost (zero) owner recovers without a step.
  always_comb begin
    owner_next  = owner_reg;
    dir_up_next = dir_up_reg;
    if (owner_reg == '0) begin
      owner_next  = NLEDS'(1);
      dir_up_next = 1'b1;
    end else if (step_tick) begin
      if (mode == LEDSEQ_FILL) begin
        owner_next = (&owner_reg) ? NLEDS'(1) : {owner_reg[NLEDS-2:0], 1'b1};
      end else if (!owner_onehot) begin
        owner_next  = NLEDS'(1);
        dir_up_next = 1'b1;
      end else begin
        case (mode)
          LEDSEQ_BOUNCE: begin
            if (dir_up_reg) begin
              if (owner_reg[NLEDS-1]) dir_up_next = 1'b0;
              else                    owner_next  = owner_reg << 1;
            end else begin
              if (owner_reg[0]) dir_up_next = 1'b1;
              else              owner_next  = owner_reg >> 1;
            end
          end
          LEDSEQ_WRAPL: owner_next = {owner_reg[NLEDS-2:0], owner_reg[NLEDS-1]};
          LEDSEQ_WRAPR: owner_next = {owner_reg[0], owner_reg[NLEDS-1:1]};
          default:      owner_next = owner_reg;
        endcase
      end
    end
  end

  // Owner and direction registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      owner_reg  <= NLEDS'(1);
      dir_up_reg <= 1'b1;
    end else begin
      owner_reg  <= owner_next;
      dir_up_reg <= dir_up_next;
    end
  end

  // Highest set owner bit (matters in fill mode where several bits are set).
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < NLEDS; i++) begin
      if (owner_reg[i]) o_pos = PW'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < NLEDS; gi++) begin : g_level
      logic [NPWM-1:0] level_reg, level_next;

      // Per-LED brightness, updated on step from the pre-step owner.
      always_comb begin
        level_next = level_reg;
        if (step_tick) begin
          if (owner_reg[gi]) level_next = '1;
`ifdef LED_SEQUENCER_HALFDECAY_EN
          else level_next = level_reg >> 1;
`else
          else if (level_reg > NPWM'(NTAIL)) level_next = NPWM'(NTAIL);
          else if (level_reg != '0)          level_next = level_reg - NPWM'(1);
`endif
        end
      end

      // Brightness level register.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) level_reg <= '0;
        else            level_reg <= level_next;
      end

      assign levels_flat[gi*NPWM +: NPWM] = level_reg;
    end
  endgenerate

  ledseq_pwm #(
    .NLEDS (NLEDS),
    .NPWM  (NPWM)
  ) u_pwm (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_levels  (levels_flat),
    .o_led     (o_led)
  );

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench for led_sequencer. Expected values are
// produced by a small position/level model and queued; DUT outputs are
// sampled on the falling clock edge and compared against the queue.
module tb_led_sequencer;

  localparam int NLEDS   = 8;
  localparam int CTRBITS = 25;
  localparam int NPWM    = 9;
  localparam int NTAIL   = 4;
  localparam int PW      = $clog2(NLEDS);

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_enable = 1'b0;
  logic [1:0]         i_mode = 2'd0;
  logic [CTRBITS-1:0] i_period = '0;
  logic [NLEDS-1:0]   o_led;
  logic               o_step;
  logic [PW-1:0]      o_pos;

  int chk_cnt = 0;
  int err_cnt = 0;
  int exp_q[$];

  // Reference model state.
  int m_pos;
  bit m_up;
  int m_lvl3;

  always #5 i_clk = ~i_clk;

  led_sequencer #(
    .NLEDS   (NLEDS),
    .CTRBITS (CTRBITS),
    .NPWM    (NPWM),
    .NTAIL   (NTAIL)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (i_enable),
    .i_mode    (i_mode),
    .i_period  (i_period),
    .o_led     (o_led),
    .o_step    (o_step),
    .o_pos     (o_pos)
  );

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  // One step of the one-hot position model.
  task automatic model_step(input int mode);
    case (mode)
      0: begin
        if (m_up) begin
          if (m_pos == NLEDS-1) m_up = 1'b0;
          else                  m_pos++;
        end else begin
          if (m_pos == 0) m_up = 1'b1;
          else            m_pos--;
        end
      end
      1: m_pos = (m_pos + 1) % NLEDS;
      2: m_pos = (m_pos + NLEDS - 1) % NLEDS;
      default: ;
    endcase
  endtask

  task automatic model_level3(input int pre_pos);
    if (pre_pos == 3) m_lvl3 = (1 << NPWM) - 1;
`ifdef LED_SEQUENCER_HALFDECAY_EN
    else m_lvl3 = m_lvl3 >> 1;
`else
    else if (m_lvl3 > NTAIL) m_lvl3 = NTAIL;
    else if (m_lvl3 > 0)     m_lvl3 = m_lvl3 - 1;
`endif
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    m_pos  = 0;
    m_up   = 1'b1;
    m_lvl3 = 0;
  endtask

  // Clock once in a one-hot mode and compare position against the model.
  task automatic run_steps(input string tag, input int mode, input int n);
    for (int k = 0; k < n; k++) begin
      model_step(mode);
      exp_q.push_back(m_pos);
      @(negedge i_clk);
      check(tag, int'(o_pos), pop_exp());
    end
  endtask

  initial begin
    int steps_seen;
    int waited;
    int duty;
    int pre;
    int fill_exp[13];

    // Reset state and step period 4.
    i_period  = CTRBITS'(4);
    i_enable  = 1'b1;
    i_mode    = 2'd0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_led", int'(o_led), 0);
    check("reset_pos", int'(o_pos), 0);
    check("reset_step", int'(o_step), 0);
    exp_q.push_back(3);
    exp_q.push_back(7);
    exp_q.push_back(11);
    i_reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      if (o_step) check("step_cycle", c, pop_exp());
    end
    check("step_missing", exp_q.size(), 0);
    exp_q.delete();
    check("pos_after_period", int'(o_pos), 3);

    // Bounce at one step per clock.
    i_period = CTRBITS'(1);
    do_reset();
    check("bounce_start", int'(o_pos), 0);
    run_steps("bounce_pos", 0, 18);

    // Wrap-left then wrap-right starting from position 6.
    do_reset();
    run_steps("pre_wrap_pos", 0, 6);
    i_mode = 2'd1;
    run_steps("wrapl_pos", 1, 3);
    i_mode = 2'd2;
    run_steps("wrapr_pos", 2, 3);

    // Freeze: period 0 holds position and suppresses steps.
    i_period   = '0;
    steps_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (o_step) steps_seen++;
    end
    check("freeze_steps", steps_seen, 0);
    check("freeze_pos", int'(o_pos), m_pos);

    // Fill wraps after all-ones; leaving fill at 0x07 reloads owner 1.
    i_period = CTRBITS'(1);
    i_mode   = 2'd3;
    do_reset();
    fill_exp = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 0, 1, 2};
    for (int k = 0; k < 13; k++) begin
      if (k == 10) i_mode = 2'd0;
      exp_q.push_back(fill_exp[k]);
      @(negedge i_clk);
      check("fill_pos", int'(o_pos), pop_exp());
    end

    // Asynchronous reset mid-operation.
    check("led_on_before_reset", int'(o_led != '0), 1);
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_rst_led", int'(o_led), 0);
    check("async_rst_pos", int'(o_pos), 0);
    check("async_rst_step", int'(o_step), 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Tail decay of LED3 measured as duty over one 512-clock PWM frame.
    i_mode   = 2'd0;
    i_period = CTRBITS'(2048);
    do_reset();
    for (int s = 1; s <= 10; s++) begin
      waited = 0;
      do begin
        @(negedge i_clk);
        waited++;
      end while (!o_step && waited < 2100);
      if (!o_step) begin
        check("step_timeout", 0, 1);
        break;
      end
      pre = m_pos;
      model_level3(pre);
      model_step(0);
      exp_q.push_back((m_lvl3 == (1 << NPWM) - 1) ? (1 << NPWM) : m_lvl3);
      repeat (2) @(negedge i_clk);
      check("decay_pos", int'(o_pos), m_pos);
      duty = 0;
      for (int c = 0; c < (1 << NPWM); c++) begin
        if (o_led[3]) duty++;
        @(negedge i_clk);
      end
      check("led3_duty", duty, pop_exp());
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
